// File: rtl/accum_share_arbiter_if.sv
// Requester, accumulator and result handshakes for accum_share_arbiter.
// master = environment side (requesters + accumulator), slave = the arbiter.
interface accum_share_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 8,
   parameter int unsigned RW   = 10
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req_valid;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               acc_valid;
   logic [DW-1:0]      acc_data;
   logic               acc_ready;
   logic               acc_res_valid;
   logic [RW-1:0]      acc_res_data;
   logic               acc_res_ready;
   logic [NREQ-1:0]    res_valid;
   logic [RW-1:0]      res_data;
   logic [NREQ-1:0]    res_ready;
   logic [OW-1:0]      owner;
   logic               busy;
   logic               err;

   modport master (
      output req_valid, req_data, acc_ready, acc_res_valid, acc_res_data, res_ready,
      input  req_ready, acc_valid, acc_data, acc_res_ready, res_valid, res_data, owner, busy, err
   );

   modport slave (
      input  req_valid, req_data, acc_ready, acc_res_valid, acc_res_data, res_ready,
      output req_ready, acc_valid, acc_data, acc_res_ready, res_valid, res_data, owner, busy, err
   );
endinterface

// File: rtl/accum_share_arbiter.sv
// Round-robin arbiter sharing one GROUP-beat accumulator among NREQ requesters.
// A tag FIFO records group owners so accumulator results route back in grant order.
module accum_share_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = 8,
   parameter int unsigned GROUP     = 4,
   parameter int unsigned RW        = 10,
   parameter int unsigned TAG_DEPTH = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   accum_share_arbiter_if.slave bus
);
   localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam int unsigned AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

   typedef enum logic [0:0] {StIdle, StLocked} state_e;

   state_e        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          err_q, err_d;
   logic [OW-1:0] tag_mem_q [TAG_DEPTH];

   logic [DW-1:0] data_arr [NREQ];
   logic [OW-1:0] sel, cand, fifo_head;
   logic          found, busy, beat, grant, pop, fifo_empty, fifo_full;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign data_arr[i] = bus.req_data[i*DW +: DW];
   end

   // First valid requester at or above rr_ptr, wrapping.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = OW'((32'(rr_ptr_q) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_head  = tag_mem_q[rd_ptr_q[AW-1:0]];

   assign busy  = (state_q == StLocked);
   assign beat  = bus.acc_valid & bus.acc_ready;
   // Full is judged before any same-cycle pop.
   assign grant = !busy && found && !fifo_full;
   assign pop   = bus.acc_res_valid & bus.acc_res_ready;

   assign bus.acc_valid     = busy & bus.req_valid[owner_q];
   assign bus.acc_data      = busy ? data_arr[owner_q] : '0;
   assign bus.req_ready     = (busy && bus.acc_ready) ? (NREQ'(1) << owner_q) : '0;
   assign bus.res_valid     = (bus.acc_res_valid && !fifo_empty) ? (NREQ'(1) << fifo_head) : '0;
   assign bus.res_data      = bus.acc_res_data;
   assign bus.acc_res_ready = !fifo_empty & bus.res_ready[fifo_head];
   assign bus.owner         = owner_q;
   assign bus.busy          = busy;
   assign bus.err           = err_q;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      wr_ptr_d   = grant ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      err_d      = err_q | (bus.acc_res_valid & fifo_empty);
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               owner_d    = sel;
               beat_cnt_d = '0;
               state_d    = StLocked;
            end
         end
         StLocked: begin
            if (beat) begin
               if (beat_cnt_q == CW'(GROUP - 1)) begin
                  beat_cnt_d = '0;
                  state_d    = StIdle;
                  rr_ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         err_q      <= err_d;
         if (grant) tag_mem_q[wr_ptr_q[AW-1:0]] <= sel;
      end
   end
endmodule
